datapath_unpack_fifo: RTL

//  Reverse-direction companion of the 128->192 packing datapath FIFO. Accepts 192-bit words at a

---
 rtl/datapath_unpack_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/datapath_unpack_fifo.sv
// Paced-write FIFO that stores 192-bit words and unpacks each one into two
// 128-bit valid/ready beats: {W[191:128], 64'h0} and then W[127:0].
module datapath_unpack_fifo #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned DEPTH_SIZE = 10,
  parameter int unsigned CLK_DIV    = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [191:0] data_in,
  output logic         wr_en_100ns,
  output logic [127:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic         full,
  output logic         empty,
  output logic         threshold,
  output logic         overflow,
  output logic         underflow
);

  localparam int unsigned PtrW = DEPTH_SIZE + 1;
  localparam logic [PtrW-1:0] HalfDepth = PtrW'(DEPTH / 2);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  logic [5:0]      cnt_q, cnt_d;
  logic            tick;
  logic [PtrW-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d, diff;
  logic [191:0]    mem [DEPTH];
  logic [191:0]    rd_word;
  // Only the low half of a popped word is still needed once beat0 is loaded.
  logic [127:0]    hold_q, hold_d;
  state_e          state_q, state_d;
  logic [127:0]    m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            wr_en, pop;

  // Pacing counter, write qualification and pointer-derived array flags.
  always_comb begin
    tick      = (cnt_q == 6'(CLK_DIV - 1));
    cnt_d     = tick ? 6'd0 : cnt_q + 6'd1;
    full      = (w_ptr_q[DEPTH_SIZE] != r_ptr_q[DEPTH_SIZE]) &&
                (w_ptr_q[DEPTH_SIZE-1:0] == r_ptr_q[DEPTH_SIZE-1:0]);
    empty     = (w_ptr_q == r_ptr_q);
    diff      = w_ptr_q - r_ptr_q;
    // diff never exceeds DEPTH, so this equals diff[DEPTH_SIZE] | diff[DEPTH_SIZE-1].
    threshold = (diff >= HalfDepth);
    // Pre-edge full gates the write; a concurrent pop does not free a slot.
    wr_en     = wr & ~full & tick & ~rst;
    w_ptr_d   = w_ptr_q + {{DEPTH_SIZE{1'b0}}, wr_en};
  end

  // Output FSM: pop into the hold register and present the two halves in order.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    m_data_d = m_data_q;
    m_last_d = m_last_q;
    pop      = 1'b0;
    rd_word  = mem[r_ptr_q[DEPTH_SIZE-1:0]];
    unique case (state_q)
      StIdle: begin
        if (!empty) pop = 1'b1;
      end
      StBeat0: begin
        if (m_ready) begin
          state_d  = StBeat1;
          m_data_d = hold_q;
          m_last_d = 1'b1;
        end
      end
      StBeat1: begin
        if (m_ready) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d  = StIdle;
            m_last_d = 1'b0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      hold_d   = rd_word[127:0];
      state_d  = StBeat0;
      m_data_d = {rd_word[191:128], 64'h0};
      m_last_d = 1'b0;
    end
    r_ptr_d = r_ptr_q + {{DEPTH_SIZE{1'b0}}, pop};
  end

  // Sticky error flags; a pop (overflow) or accepted write (underflow) wins over a set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (pop)                  ovf_d = 1'b0;
    else if (wr & full & tick) ovf_d = 1'b1;
    if (wr_en)                 unf_d = 1'b0;
    else if (m_ready & ~m_valid) unf_d = 1'b1;
  end

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_ptr_q[DEPTH_SIZE-1:0]] <= data_in;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      w_ptr_q  <= '0;
      r_ptr_q  <= '0;
      hold_q   <= '0;
      state_q  <= StIdle;
      m_data_q <= '0;
      m_last_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      w_ptr_q  <= w_ptr_d;
      r_ptr_q  <= r_ptr_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_last_q <= m_last_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_en_100ns = wr_en;
  assign m_data      = m_data_q;
  assign m_valid     = (state_q != StIdle);
  assign m_last      = m_last_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule
